// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit.
// Holds the fetch FSM state encoding, the NOP word, the default reset PC,
// the skid payload layout and the opcode/funct constants decoded by control_unit.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned SKID_W           = 64;

  // Fetched word tagged with its address; this is the skid payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Opcode field inst[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct field inst[5:0] for R-type
  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Sequential next PC; 32-bit add wraps naturally.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_skid.sv
// fetch_skid_buf: single-entry holding register for a fetched word that
// arrived while the output register was full and stalled.
// Ports: clk, rst_n (sync, active low), load/unload/flush controls,
//        din/dout 64-bit {pc, word} payload, valid = entry occupied.
module fetch_skid_buf
  import instr_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [SKID_W-1:0] din,
  output logic              valid,
  output logic [SKID_W-1:0] dout
);

  logic              valid_q, valid_d;
  logic [SKID_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetcher feeding the control unit.
// Issues one word request at a time, presents fetched words in program order
// through an output register plus a 1-entry skid, and handles redirects,
// including redirects that land while a memory request is still in flight.
// Ports: clk, rst_n (sync, active low); imem_req/imem_addr/imem_ready/
//        imem_rdata memory side; stall, redirect_valid/redirect_pc control;
//        inst_valid/inst/inst_pc output to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  disc_addr_q, disc_addr_d;  // address of the request being discarded
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;

  logic         skid_load, skid_unload, skid_flush, skid_valid;
  fetch_entry_t skid_in, skid_out;

  logic         consume;
  logic [31:0]  redir_pc;

  assign consume  = inst_valid_q && !stall;
  assign redir_pc = word_align(redirect_pc);
  assign skid_in  = '{pc: pc_q, word: imem_rdata};

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .unload (skid_unload),
    .flush  (skid_flush),
    .din    (skid_in),
    .valid  (skid_valid),
    .dout   (skid_out)
  );

  // A request in flight during DISCARD must keep its original address until
  // the memory completes it, while pc_q already holds the redirect target.
  assign imem_req  = rst_n && (state_q != HOLD);
  assign imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    disc_addr_d  = disc_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q && !consume;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;

    if (redirect_valid) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP;
      skid_flush   = 1'b1;
      pc_d         = redir_pc;
    end

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (!imem_ready) begin
            state_d     = DISCARD;
            disc_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          pc_d = pc_next(pc_q);
          if (!inst_valid_q || !stall) begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = FETCH;
        end else if (!stall) begin
          inst_d       = skid_out.word;
          inst_pc_d    = skid_out.pc;
          inst_valid_d = skid_valid;
          skid_unload  = 1'b1;
          state_d      = FETCH;
        end
      end
      DISCARD: begin
        // A redirect here only retargets pc_q; the old request still has to
        // drain, so the state leaves DISCARD only when the memory responds.
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      disc_addr_q  <= '0;
      inst_q       <= NOP;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      disc_addr_q  <= disc_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word address of the first instruction fetched after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  output  32  fetch address, word-aligned.
REQ-006 Port: imem_ready  input  1  memory completes the request this cycle; imem_rdata valid.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: stall  input  1  downstream decode/control stage cannot accept inst this cycle.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect; flush and refetch.
REQ-010 Port: redirect_pc  input  32  redirect target address.
REQ-011 Port: inst_valid  output  1  inst/inst_pc hold a valid instruction for the control unit.
REQ-012 Port: inst  output  32  instruction word; bits [31:26] opcode, [5:0] funct for the control unit.
REQ-013 Port: inst_pc  output  32  address of inst.

Function
REQ-014 States SHALL be FETCH, HOLD, DISCARD; the state after reset SHALL be FETCH.
REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; in HOLD, imem_req SHALL be 0.
REQ-016 Once asserted, imem_req and imem_addr SHALL remain stable until the cycle imem_ready=1 (no mid-request abort).
REQ-017 Handover: the output register is consumed in any cycle where inst_valid=1 and stall=0.
REQ-018 FETCH with imem_ready=1 and the output register empty or being consumed: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4; remain in FETCH (back-to-back fetch, one instruction per cycle with a zero-wait memory).
REQ-019 FETCH with imem_ready=1 while the output register is full and stall=1: the word and its pc SHALL go to a 1-entry skid buffer, pc<=pc+4, next state HOLD.
REQ-020 HOLD with stall=0: the skid entry SHALL move to the output register, the skid SHALL empty, next state FETCH.
REQ-021 FETCH with imem_ready=0: when the output register is consumed and no new word arrives, inst_valid<=0.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 redirect_valid=1 SHALL take priority over stall and all other events: inst_valid<=0, inst<=32'h0, skid emptied, pc<={redirect_pc[31:2],2'b00}.
REQ-024 Redirect in FETCH with imem_ready=0 (request outstanding): next state DISCARD; the old request stays asserted at its old address until imem_ready, its data SHALL be dropped, and then next state FETCH at the new pc.
REQ-025 Redirect coinciding with imem_ready=1: the returned word SHALL be dropped; next state FETCH at the redirected pc.
REQ-026 Redirect while in DISCARD SHALL overwrite the pending target pc; the state remains DISCARD.
REQ-027 Redirect in HOLD: next state FETCH at the redirected pc.
REQ-028 Instructions SHALL reach inst in program order, never duplicated, never dropped except by a redirect.

Reset
REQ-029 While rst_n=0 at a clock edge: pc<=RESET_PC, state<=FETCH, skid emptied, inst_valid<=0, inst<=32'h0, inst_pc<=32'h0; imem_req SHALL be 0 during reset.
REQ-030 Reset asserted mid-request SHALL abandon the request with no discard tracking; the memory is reset on the same rst_n.
REQ-031 The first request SHALL issue in the first cycle after rst_n rises, with imem_addr=RESET_PC.

Structure
REQ-032 Shared package SHALL hold the state enum, the NOP constant 32'h0, the RESET_PC default, and the opcode/funct constants shared with control_unit.
REQ-033 The skid buffer SHALL be a sub-module, fetch_skid_buf (1 entry, 64 bits payload, load/unload/flush).

Verification
REQ-034 Reset, then a zero-wait memory returning addr-based words -> inst_pc=0x0,0x4,0x8 on consecutive cycles with inst_valid=1.
REQ-035 Memory returning ready after 3 cycles -> imem_addr stable for 3 cycles; inst_valid pulses once per word.
REQ-036 stall=1 for 4 cycles during streaming -> inst held, one word in skid, imem_req=0; after release, words arrive in order with none lost or duplicated.
REQ-037 redirect_valid=1 with redirect_pc=0x100 while a 2-cycle request to 0x8 is outstanding -> word for 0x8 never appears; the next inst_pc is 0x100.
REQ-038 redirect_pc=0x203 coinciding with imem_ready and stall=1 -> flush; the next fetch address is 0x200.
REQ-039 pc=0xFFFF_FFFC, fetch -> the next imem_addr is 0x0000_0000.
